tone_sequencer: RTL and testbench

- Control FSM for the tone-generator datapath.
- Takes one-cycle button pulses (debounced and edge-detected upstream) and drives freq_sel, amp_sel and noise_enable into the frequency controller, amplitude controller and audio mixer.
- Frequency changes are click-free: fade amplitude down, swap frequency at a phase-accumulator wrap, fade back up.
- Amplitude changes ramp one step at a time. Noise toggles are applied only at a phase wrap.

---
 rtl/tone_sequencer_if.sv | 24 ++
 rtl/tone_sequencer.sv | 138 +++++++++++++
 tb/tb_tone_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// Control/status bundle between the tone sequencer and its surroundings.
// The slave side is the sequencer; the master side supplies strobes and button pulses.
interface tone_sequencer_if;
    logic       sample_tick;
    logic       phase_wrap;
    logic       freq_btn;
    logic       amp_btn;
    logic       noise_btn;
    logic [1:0] freq_sel;
    logic [1:0] amp_sel;
    logic       noise_enable;
    logic       mute;
    logic       busy;

    modport master (
        output sample_tick, phase_wrap, freq_btn, amp_btn, noise_btn,
        input  freq_sel, amp_sel, noise_enable, mute, busy
    );

    modport slave (
        input  sample_tick, phase_wrap, freq_btn, amp_btn, noise_btn,
        output freq_sel, amp_sel, noise_enable, mute, busy
    );
endinterface

// File: rtl/tone_sequencer.sv
// Tone-generator control FSM: click-free frequency swaps (fade out, swap at a phase
// wrap, fade in), stepped amplitude ramps and wrap-aligned noise toggling.
module tone_sequencer #(
    parameter int unsigned RAMP_TICKS   = 64,
    parameter int unsigned WRAP_TIMEOUT = 1024
) (
    input logic             clk,
    input logic             reset,
    tone_sequencer_if.slave bus
);

    localparam int unsigned RampW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam int unsigned WrapW = (WRAP_TIMEOUT > 1) ? $clog2(WRAP_TIMEOUT) : 1;
    localparam logic [RampW-1:0] RampLast = RampW'(RAMP_TICKS - 1);
    localparam logic [WrapW-1:0] WrapLast = WrapW'(WRAP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFadeOut,
        StWaitWrap,
        StSwap,
        StFadeIn
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       freq_sel_q, freq_sel_d;
    logic [1:0]       freq_target_q, freq_target_d;
    logic [1:0]       amp_sel_q, amp_sel_d;
    logic [1:0]       amp_target_q, amp_target_d;
    logic             noise_enable_q, noise_enable_d;
    logic             noise_pending_q, noise_pending_d;
    logic [RampW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [WrapW-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             ramp_evt;
    logic             wrap_done;
    logic             noise_apply;

    assign ramp_evt  = bus.sample_tick && (ramp_cnt_q == RampLast);
    assign wrap_done = bus.sample_tick && (wrap_cnt_q == WrapLast);

    always_comb begin
        state_d     = state_q;
        freq_sel_d  = freq_sel_q;
        amp_sel_d   = amp_sel_q;
        noise_apply = 1'b0;

        case (state_q)
            StIdle: begin
                if (freq_target_q != freq_sel_q) begin
                    state_d = StFadeOut;
                end else if (ramp_evt && (amp_sel_q < amp_target_q)) begin
                    amp_sel_d = amp_sel_q + 2'd1;
                end else if (ramp_evt && (amp_sel_q > amp_target_q)) begin
                    amp_sel_d = amp_sel_q - 2'd1;
                end
                noise_apply = bus.phase_wrap && noise_pending_q;
            end
            StFadeOut: begin
                if (amp_sel_q == 2'd0) begin
                    state_d = StWaitWrap;
                end else if (ramp_evt) begin
                    amp_sel_d = amp_sel_q - 2'd1;
                end
            end
            StWaitWrap: begin
                if (bus.phase_wrap || wrap_done) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                freq_sel_d  = freq_target_q;
                noise_apply = noise_pending_q;
                state_d     = StFadeIn;
            end
            StFadeIn: begin
                if (amp_sel_q >= amp_target_q) begin
                    state_d = StIdle;
                end else if (ramp_evt) begin
                    amp_sel_d = amp_sel_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Ramp phase restarts with every state change so each stage gets full intervals.
        if (state_d != state_q) begin
            ramp_cnt_d = '0;
        end else if (bus.sample_tick) begin
            ramp_cnt_d = ramp_evt ? '0 : ramp_cnt_q + RampW'(1);
        end else begin
            ramp_cnt_d = ramp_cnt_q;
        end

        if ((state_q == StWaitWrap) && (state_d == StWaitWrap)) begin
            wrap_cnt_d = bus.sample_tick ? wrap_cnt_q + WrapW'(1) : wrap_cnt_q;
        end else begin
            wrap_cnt_d = '0;
        end

        // A press coinciding with an application re-arms pending for the next wrap.
        noise_enable_d  = noise_enable_q ^ noise_apply;
        noise_pending_d = (noise_pending_q & ~noise_apply) ^ bus.noise_btn;
        freq_target_d   = freq_target_q + {1'b0, bus.freq_btn};
        amp_target_d    = amp_target_q + {1'b0, bus.amp_btn};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            freq_sel_q      <= 2'b01;
            freq_target_q   <= 2'b01;
            amp_sel_q       <= 2'b01;
            amp_target_q    <= 2'b01;
            noise_enable_q  <= 1'b0;
            noise_pending_q <= 1'b0;
            ramp_cnt_q      <= '0;
            wrap_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            freq_sel_q      <= freq_sel_d;
            freq_target_q   <= freq_target_d;
            amp_sel_q       <= amp_sel_d;
            amp_target_q    <= amp_target_d;
            noise_enable_q  <= noise_enable_d;
            noise_pending_q <= noise_pending_d;
            ramp_cnt_q      <= ramp_cnt_d;
            wrap_cnt_q      <= wrap_cnt_d;
        end
    end

    assign bus.freq_sel     = freq_sel_q;
    assign bus.amp_sel      = amp_sel_q;
    assign bus.noise_enable = noise_enable_q;
    assign bus.mute         = (state_q == StWaitWrap) || (state_q == StSwap);
    assign bus.busy         = (state_q != StIdle) || (amp_sel_q != amp_target_q) ||
                              noise_pending_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized bench for tone_sequencer: a reference model predicts every cycle's outputs
// into a scoreboard queue that an independent monitor drains and compares.
module tb_tone_sequencer;

    localparam int unsigned RT = 4;
    localparam int unsigned WT = 8;
    localparam int NSEG   = 5;
    localparam int SEGLEN = 600;

    logic clk = 1'b0;
    logic reset = 1'b1;
    tone_sequencer_if bus ();

    tone_sequencer #(.RAMP_TICKS(RT), .WRAP_TIMEOUT(WT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] freq;
        logic [1:0] amp;
        logic       noise;
        logic       mute;
        logic       busy;
        bit         after_reset;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    int cycle = 0;

    // Reference model: phases of a frequency change as plain integers.
    localparam int PH_IDLE = 0, PH_DOWN = 1, PH_WAIT = 2, PH_SWAP = 3, PH_UP = 4;
    int m_phase, m_freq, m_ftgt, m_amp, m_atgt, m_noise, m_pend, m_ticks, m_waited;

    function automatic void model_reset();
        m_phase = PH_IDLE; m_freq = 1; m_ftgt = 1; m_amp = 1; m_atgt = 1;
        m_noise = 0; m_pend = 0; m_ticks = 0; m_waited = 0;
    endfunction

    function automatic void model_step(input bit rst, input bit tick, input bit wrap,
                                       input bit fb, input bit ab, input bit nb);
        int  nph;
        bit  step;
        bit  apply;
        if (rst) begin
            model_reset();
            return;
        end
        step  = tick && (m_ticks == int'(RT) - 1);
        nph   = m_phase;
        apply = 0;
        if (m_phase == PH_IDLE) begin
            if (m_ftgt != m_freq) nph = PH_DOWN;
            else if (step && m_amp != m_atgt) m_amp += (m_amp < m_atgt) ? 1 : -1;
            apply = wrap && m_pend != 0;
        end else if (m_phase == PH_DOWN) begin
            if (m_amp == 0) nph = PH_WAIT;
            else if (step) m_amp -= 1;
        end else if (m_phase == PH_WAIT) begin
            if (wrap || (tick && m_waited + 1 == int'(WT))) nph = PH_SWAP;
        end else if (m_phase == PH_SWAP) begin
            m_freq = m_ftgt;
            apply  = m_pend != 0;
            nph    = PH_UP;
        end else begin
            if (m_amp >= m_atgt) nph = PH_IDLE;
            else if (step) m_amp += 1;
        end
        if (nph == PH_WAIT && m_phase == PH_WAIT) m_waited += tick ? 1 : 0;
        else m_waited = 0;
        if (nph != m_phase) m_ticks = 0;
        else if (tick) m_ticks = step ? 0 : m_ticks + 1;
        if (apply) begin
            m_noise = 1 - m_noise;
            m_pend  = 0;
        end
        if (nb) m_pend = 1 - m_pend;
        m_ftgt  = (m_ftgt + (fb ? 1 : 0)) % 4;
        m_atgt  = (m_atgt + (ab ? 1 : 0)) % 4;
        m_phase = nph;
    endfunction

    function automatic exp_t model_outputs(input bit rst);
        exp_t e;
        e.freq        = 2'(m_freq);
        e.amp         = 2'(m_amp);
        e.noise       = m_noise[0];
        e.mute        = (m_phase == PH_WAIT) || (m_phase == PH_SWAP);
        e.busy        = (m_phase != PH_IDLE) || (m_amp != m_atgt) || (m_pend != 0);
        e.after_reset = rst;
        return e;
    endfunction

    // Monitor: one expected item per clock, compared just after the edge.
    logic [1:0] prev_freq, prev_amp;
    bit prev_valid = 0;
    initial begin
        exp_t e;
        int   d;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({bus.freq_sel, bus.amp_sel, bus.noise_enable, bus.mute, bus.busy} !==
                    {e.freq, e.amp, e.noise, e.mute, e.busy}) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got freq=%0d amp=%0d noise=%0d mute=%0d busy=%0d want freq=%0d amp=%0d noise=%0d mute=%0d busy=%0d",
                             cycle, bus.freq_sel, bus.amp_sel, bus.noise_enable, bus.mute,
                             bus.busy, e.freq, e.amp, e.noise, e.mute, e.busy);
                end
                if (prev_valid && !e.after_reset) begin
                    checks++;
                    d = int'(bus.amp_sel) - int'(prev_amp);
                    if ((d > 1) || (d < -1) ||
                        ((bus.freq_sel !== prev_freq) && (bus.amp_sel !== prev_amp))) begin
                        failures++;
                        $display("FAIL step_rule cyc=%0d got freq %0d->%0d amp %0d->%0d want single amp step and no joint change",
                                 cycle, prev_freq, bus.freq_sel, prev_amp, bus.amp_sel);
                    end
                end
                prev_freq  = bus.freq_sel;
                prev_amp   = bus.amp_sel;
                prev_valid = 1;
            end
        end
    end

    // Per-segment rates in per-mille: tick, wrap, each button, reset.
    int tick_pm[NSEG] = '{1000, 1000, 400, 1000, 1000};
    int wrap_pm[NSEG] = '{30, 0, 100, 200, 15};
    int btn_pm[NSEG]  = '{20, 20, 40, 60, 10};
    int rst_pm[NSEG]  = '{0, 0, 0, 4, 2};

    task automatic drive(input bit rst, input bit tick, input bit wrap,
                         input bit fb, input bit ab, input bit nb);
        @(negedge clk);
        reset           = rst;
        bus.sample_tick = tick;
        bus.phase_wrap  = wrap;
        bus.freq_btn    = fb;
        bus.amp_btn     = ab;
        bus.noise_btn   = nb;
        model_step(rst, tick, wrap, fb, ab, nb);
        sb_q.push_back(model_outputs(rst));
        cycle++;
    endtask

    initial begin
        bus.sample_tick = 0;
        bus.phase_wrap  = 0;
        bus.freq_btn    = 0;
        bus.amp_btn     = 0;
        bus.noise_btn   = 0;
        model_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        for (int s = 0; s < NSEG; s++) begin
            for (int i = 0; i < SEGLEN; i++) begin
                drive($urandom_range(0, 999) < rst_pm[s],
                      $urandom_range(0, 999) < tick_pm[s],
                      $urandom_range(0, 999) < wrap_pm[s],
                      $urandom_range(0, 999) < btn_pm[s],
                      $urandom_range(0, 999) < btn_pm[s],
                      $urandom_range(0, 999) < btn_pm[s]);
            end
        end
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending items want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
